// File: rtl/axi_lite_write_arbiter.sv
// axi_lite_write_arbiter: round-robin arbiter sharing one AXI4-lite write port among NUM_REQ requesters
module axi_lite_write_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int AXI_ADDR_WIDTH = 64,
   parameter int AXI_DATA_WIDTH = 64
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0] req_addr_i,
   input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0] req_data_i,
   output logic [NUM_REQ-1:0]            done_o,
   output logic [NUM_REQ-1:0]            err_o,
   output logic                          busy_o,
   output logic                          aw_valid_o,
   input  logic                          aw_ready_i,
   output logic [AXI_ADDR_WIDTH-1:0]     aw_addr_o,
   output logic                          w_valid_o,
   input  logic                          w_ready_i,
   output logic [AXI_DATA_WIDTH-1:0]     w_data_o,
   output logic [AXI_DATA_WIDTH/8-1:0]   w_strb_o,
   input  logic                          b_valid_i,
   output logic                          b_ready_o,
   input  logic [1:0]                    b_resp_i
);
   localparam int IW = $clog2(NUM_REQ);
   typedef enum logic [1:0] {IDLE, WRITE, RESP} state_t;
   state_t state;
   logic [IW-1:0] rr_ptr, gnt, win;
   logic found, aw_done, w_done, aw_hs, w_hs;
   // descending scan so the requester closest to rr_ptr is assigned last and wins
   always_comb begin
      win = '0;
      found = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--)
         if (req_valid_i[IW'((int'(rr_ptr) + i) % NUM_REQ)]) begin
            win = IW'((int'(rr_ptr) + i) % NUM_REQ);
            found = 1'b1;
         end
   end
   assign req_ready_o = (rst_ni && state == IDLE && found) ? NUM_REQ'(1) << win : '0;
   assign busy_o = state != IDLE;
   assign w_strb_o = '1;
   assign aw_hs = aw_valid_o & aw_ready_i;
   assign w_hs = w_valid_o & w_ready_i;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
         rr_ptr <= '0;
         gnt <= '0;
         aw_done <= 1'b0;
         w_done <= 1'b0;
         aw_valid_o <= 1'b0;
         w_valid_o <= 1'b0;
         b_ready_o <= 1'b0;
         aw_addr_o <= '0;
         w_data_o <= '0;
         done_o <= '0;
         err_o <= '0;
      end else begin
         done_o <= '0;
         err_o <= '0;
         case (state)
            IDLE: if (found) begin
               gnt <= win;
               aw_addr_o <= req_addr_i[win*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
               w_data_o <= req_data_i[win*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
               aw_valid_o <= 1'b1;
               w_valid_o <= 1'b1;
               aw_done <= 1'b0;
               w_done <= 1'b0;
               state <= WRITE;
            end
            WRITE: begin
               if (aw_hs) begin
                  aw_valid_o <= 1'b0;
                  aw_done <= 1'b1;
               end
               if (w_hs) begin
                  w_valid_o <= 1'b0;
                  w_done <= 1'b1;
               end
               if ((aw_done | aw_hs) & (w_done | w_hs)) begin
                  b_ready_o <= 1'b1;
                  state <= RESP;
               end
            end
            RESP: if (b_valid_i & b_ready_o) begin
               done_o[gnt] <= 1'b1;
               err_o[gnt] <= b_resp_i >= 2'b10;
               b_ready_o <= 1'b0;
               rr_ptr <= (gnt == IW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
